// File: rtl/commit_trace_unit.sv
// ============================================================================
// Module      : commit_trace_unit
// Description : Carries fetched {PC, Inst} alongside the pipeline, joins it with
//               memory/writeback side effects and emits one commit record per
//               retired instruction; also owns cycle/inst counters and halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_unit #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_valid,
    input  logic [15:0]      f_pc,
    input  logic [15:0]      f_inst,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_memread,
    input  logic             m_memwrite,
    input  logic [15:0]      m_addr,
    input  logic [15:0]      m_wdata,
    input  logic             m_halt,
    input  logic             w_regwrite,
    input  logic [2:0]       w_reg,
    input  logic [15:0]      w_data,
    output logic             cm_valid,
    output logic [15:0]      cm_pc,
    output logic [15:0]      cm_inst,
    output logic             cm_regwrite,
    output logic             cm_memread,
    output logic             cm_memwrite,
    output logic             cm_halt,
    output logic [2:0]       cm_wreg,
    output logic [15:0]      cm_wdata,
    output logic [15:0]      cm_addr,
    output logic [15:0]      cm_mdata,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic             halted
);

    localparam int c_MEM = STAGES - 2;
    localparam int c_WB  = STAGES - 1;

    typedef struct packed {
        logic        v;
        logic [15:0] pc;
        logic [15:0] inst;
    } slot_t;

    // Slot 0 is D, slot 1 is X, slot c_WB is W.
    slot_t            r_slot [STAGES];
    logic             r_memread;
    logic             r_memwrite;
    logic             r_halt;
    logic [15:0]      r_addr;
    logic [15:0]      r_mdata;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_inst_count;
    logic             r_halted;

    logic             w_cm_valid;

    assign w_cm_valid = r_slot[c_WB].v & ~r_halted;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_slot[i] <= '0;
            end
            r_memread     <= 1'b0;
            r_memwrite    <= 1'b0;
            r_halt        <= 1'b0;
            r_addr        <= '0;
            r_mdata       <= '0;
            r_cycle_count <= '0;
            r_inst_count  <= '0;
            r_halted      <= 1'b0;
        end else if (!r_halted) begin
            // The instruction in X at a flushing edge is the branch: it still advances.
            if (flush) begin
                r_slot[0] <= '0;
                r_slot[1] <= '0;
            end else if (stall) begin
                r_slot[1] <= '0;
            end else begin
                r_slot[0] <= f_valid ? slot_t'{v: 1'b1, pc: f_pc, inst: f_inst} : '0;
                r_slot[1] <= r_slot[0];
            end
            for (int i = 2; i < STAGES; i++) begin
                r_slot[i] <= r_slot[i-1];
            end

            if (r_slot[c_MEM].v) begin
                r_memread  <= m_memread;
                r_memwrite <= m_memwrite;
                r_halt     <= m_halt;
                r_addr     <= m_addr;
                r_mdata    <= m_wdata;
            end else begin
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_halt     <= 1'b0;
                r_addr     <= '0;
                r_mdata    <= '0;
            end

            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (w_cm_valid) begin
                r_inst_count <= r_inst_count + CNT_W'(1);
            end
            if (w_cm_valid && r_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign cm_valid    = w_cm_valid;
    assign cm_pc       = w_cm_valid ? r_slot[c_WB].pc   : 16'h0000;
    assign cm_inst     = w_cm_valid ? r_slot[c_WB].inst : 16'h0000;
    assign cm_regwrite = w_cm_valid & w_regwrite;
    assign cm_memread  = w_cm_valid & r_memread;
    assign cm_memwrite = w_cm_valid & r_memwrite;
    assign cm_halt     = w_cm_valid & r_halt;
    assign cm_wreg     = w_cm_valid ? w_reg   : 3'd0;
    assign cm_wdata    = w_cm_valid ? w_data  : 16'h0000;
    assign cm_addr     = w_cm_valid ? r_addr  : 16'h0000;
    assign cm_mdata    = w_cm_valid ? r_mdata : 16'h0000;
    assign cycle_count = r_cycle_count;
    assign inst_count  = r_inst_count;
    assign halted      = r_halted;

endmodule

`default_nettype wire
